// File: rtl/probe_capture_pkg.sv
// probe_capture_pkg: shared state encoding and trigger mode constants for the probe capture core
package probe_capture_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_WAIT    = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;
  localparam logic [1:0] TM_LEVEL  = 2'b00;
  localparam logic [1:0] TM_ENTRY  = 2'b01;
  localparam logic [1:0] TM_CHANGE = 2'b10;
endpackage

// File: rtl/probe_capture_ram.sv
// probe_capture_ram: simple dual-port sample buffer, sync write, registered sync read
module probe_capture_ram #(
  parameter int W = 9,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [W-1:0]  wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [W-1:0]  rd_o
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem[wa_i] <= wd_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rd_o <= '0;
    else rd_o <= mem[ra_i];
endmodule

// File: rtl/probe_capture_la.sv
// probe_capture_la: circular-buffer probe capture with mask/value, entry and change triggers
module probe_capture_la
  import probe_capture_pkg::*;
#(
  parameter int PROBE_W = 9,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [PROBE_W-1:0] probe_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [PROBE_W-1:0] trig_mask_i,
  input  logic [PROBE_W-1:0] trig_value_i,
  input  logic [1:0]         trig_mode_i,
  input  logic [7:0]         trig_count_i,
  input  logic [AW-1:0]      post_len_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [PROBE_W-1:0] rd_data_o,
  output logic [2:0]         state_o,
  output logic               busy_o,
  output logic               done_o
);
  state_t state, state_nx;
  logic [PROBE_W-1:0] mask, value, prev;
  logic [1:0] mode;
  logic [7:0] tcount, ev_cnt, tc_eff;
  logic [AW-1:0] post_len, pre, pre_in, wr_ptr, cnt;
  logic prev_valid, m, m_prev, ev, trig, start;
  assign busy_o = state inside {ST_PREFILL, ST_WAIT, ST_POST};
  assign done_o = state == ST_DONE;
  assign state_o = state;
  assign start = arm_i && !abort_i && (state == ST_IDLE || state == ST_DONE);
  assign pre_in = AW'(DEPTH - 1) - post_len_i;
  assign pre = AW'(DEPTH - 1) - post_len;
  assign m = ((probe_i ^ value) & mask) == '0;
  assign m_prev = ((prev ^ value) & mask) == '0;
  assign ev = (mode == TM_ENTRY) ? m & prev_valid & !m_prev :
              (mode == TM_CHANGE) ? prev_valid & (|((probe_i ^ prev) & mask)) : m;
  assign tc_eff = (tcount == 8'd0) ? 8'd1 : tcount;
  assign trig = state == ST_WAIT && ev && ({1'b0, ev_cnt} + 9'd1 == {1'b0, tc_eff});
  always_comb begin
    state_nx = state;
    if (abort_i) state_nx = ST_IDLE;
    else case (state)
      ST_IDLE, ST_DONE: if (arm_i) state_nx = (pre_in == '0) ? ST_WAIT : ST_PREFILL;
      ST_PREFILL: if (cnt == pre - AW'(1)) state_nx = ST_WAIT;
      ST_WAIT: if (trig) state_nx = (post_len == '0) ? ST_DONE : ST_POST;
      ST_POST: if (cnt == post_len - AW'(1)) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= ST_IDLE;
      wr_ptr <= '0;
      cnt <= '0;
      ev_cnt <= '0;
      prev_valid <= 1'b0;
      prev <= '0;
      mask <= '0;
      value <= '0;
      mode <= TM_LEVEL;
      tcount <= '0;
      post_len <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        mask <= trig_mask_i;
        value <= trig_value_i;
        mode <= trig_mode_i;
        tcount <= trig_count_i;
        post_len <= post_len_i;
        ev_cnt <= '0;
        prev_valid <= 1'b0;
        cnt <= '0;
      end
      if (busy_o) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev <= probe_i;
        prev_valid <= 1'b1;
        cnt <= (state_nx != state) ? '0 : cnt + AW'(1);
      end
      if (state == ST_WAIT && ev) ev_cnt <= ev_cnt + 8'd1;
    end
  // wr_ptr is frozen outside capture, so in DONE it is the oldest sample
  probe_capture_ram #(.W(PROBE_W), .DEPTH(DEPTH)) u_ram (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .we_i(busy_o),
    .wa_i(wr_ptr),
    .wd_i(probe_i),
    .ra_i(wr_ptr + rd_addr_i),
    .rd_o(rd_data_o)
  );
endmodule

// File: doc/probe_capture_la.md
# probe_capture_la

Parametrised in-fabric probe capture core for the LVDS 7:1 receive path. It samples a probe bus every `clk_i` cycle into a circular buffer and stops after a configurable post-trigger length. Triggering uses mask/value, edge or change detection with an occurrence counter. It sits in the `rx_sclk` domain beside the bit-alignment controller, where it typically watches `phase_flag` plus status bits. The captured window is read back through a synchronous read port by a local register/UART bridge, so no JTAG analyzer core is required.

## Interface
Parameters:
- `PROBE_W`, 9, probe bus width (1..64)
- `DEPTH`, 256, buffer depth in samples; power of two, ≥4
- `AW`, `$clog2(DEPTH)`, address width (derived; not overridden)

Ports:
- `clk_i`  in  1  capture clock (driven by `rx_sclk`)
- `rst_n_i`  in  1  reset; one clock, reset asynchronous active-low
- `probe_i`  in  PROBE_W  sampled bus
- `arm_i`  in  1  single-cycle pulse; latches config, starts capture
- `abort_i`  in  1  single-cycle pulse; returns to IDLE
- `trig_mask_i`  in  PROBE_W  bits participating in trigger
- `trig_value_i`  in  PROBE_W  compare value
- `trig_mode_i`  in  2  00 level match, 01 match-entry, 10 masked change, 11 = 00
- `trig_count_i`  in  8  events required; 0 treated as 1
- `post_len_i`  in  AW  samples stored after trigger sample, 0..DEPTH-1
- `rd_addr_i`  in  AW  logical read address, 0 = oldest sample
- `rd_data_o`  out  PROBE_W  read data, 1-cycle latency
- `state_o`  out  3  current state encoding
- `busy_o`  out  1  high in PREFILL/WAIT_TRIG/POST
- `done_o`  out  1  high in DONE

## Operation
- States: IDLE(0), PREFILL(1), WAIT_TRIG(2), POST(3), DONE(4).
- IDLE/DONE + `arm_i`:
  - latch mask, value, mode, count and post_len; clear event counter and `prev_valid`.
  - go to PREFILL, or straight to WAIT_TRIG if `pre = DEPTH-1-post_len` is 0.
- `arm_i` in PREFILL, WAIT_TRIG or POST is ignored. `abort_i` in any state goes to IDLE. `abort_i` wins over a simultaneous `arm_i`.
- In PREFILL, WAIT_TRIG and POST, every cycle writes `probe_i` to `wr_ptr` and increments `wr_ptr` mod DEPTH. Each written sample is also stored as `prev`, and `prev_valid` is set to 1.
- PREFILL writes exactly `pre` samples, then enters WAIT_TRIG. No trigger evaluation happens in PREFILL.
- WAIT_TRIG defines `m = ((probe_i ^ trig_value) & trig_mask) == 0`. The event condition depends on mode:
  - mode 00: `m`
  - mode 01: `m & prev_valid & !m_prev`
  - mode 10: `prev_valid & ((probe_i ^ prev) & trig_mask) != 0`
- All-zero mask in modes 00/01: `m` is constant 1, so mode 00 fires immediately and mode 01 never fires.
- On each event the counter increments. The event that brings the counter to `trig_count` (0 treated as 1) is the trigger sample, written in that same cycle.
- After the trigger: go to POST if `post_len > 0`, else to DONE.
- POST writes `post_len` further samples, then goes to DONE.
- DONE: no writes. `start_ptr` = `wr_ptr` at entry. Read physical address = `(start_ptr + rd_addr_i) mod DEPTH`. The trigger sample sits at logical address `DEPTH-1-post_len`.
- WAIT_TRIG may last indefinitely; the buffer overwrites circularly. Every location is valid at DONE, because at least DEPTH samples have been written since arm.
- Reads outside DONE return unspecified data but must not corrupt the buffer.

## Timing
- Reset values: state IDLE, `state_o`=0, `busy_o`=0, `done_o`=0, `rd_data_o`=0, `wr_ptr`=0, counters 0, `prev_valid`=0.
- Arm latency: sample 0 is the `probe_i` value on the cycle after `arm_i`.
- Trigger: detected combinationally from `probe_i` and registered state; the state advances on that clock edge.
- `done_o` rises on the edge that writes the last POST sample, or on the trigger-sample edge if `post_len`=0.
- Total from arm to done when the trigger fires at first opportunity: DEPTH cycles.
- `rd_data_o` updates one edge after `rd_addr_i` and holds between address changes.
- Reset mid-capture: immediate return to IDLE; buffer contents undefined.

## Structure
- Package `probe_capture_pkg`: state enum, `trig_mode` constants (`TM_LEVEL`, `TM_ENTRY`, `TM_CHANGE`), state encodings.
- Sub-module `probe_capture_ram`: simple dual-port RAM, DEPTH×PROBE_W, sync write, sync registered read, no reset on the array. The output register is reset to 0.
- FSM, pointers and trigger logic live in `probe_capture_la`.

## Test plan
- DEPTH=16, PROBE_W=9, counter ramp on probe, mode 00, mask=0x1FF, value=0x020, post_len=4 -> done; logical addr 11 = 0x020, addr 0 = 0x015, addr 15 = 0x024.
- Mode 01, mask=0x001, value=0x001, probe toggling bit0 each cycle, trig_count=3 -> trigger on the third 0→1 entry; sample at logical addr `DEPTH-1-post_len` has bit0=1.
- Mode 10, mask=0x100, probe static 0x000 for 40 cycles, then 0x100 -> trigger sample = 0x100; preceding 15−post_len samples = 0x000.
- post_len=15 with mode 01 and probe already matching at arm -> no trigger on the first WAIT cycle (`prev_valid`=0); `state_o`=2 persists.
- `abort_i` during POST -> `state_o`=0 next cycle, `done_o`=0. `arm_i` with `abort_i` in the same cycle -> IDLE. `arm_i` during WAIT_TRIG -> ignored; config unchanged.
- `rst_n_i` asserted asynchronously mid-POST -> all outputs at reset values before the next edge; re-arm completes a normal capture.
